// File: rtl/ctrl_regfptr.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_regfptr
// Description : Per-channel sample ring pointer keeper and register-file
//               address walker. On en_load it emits up to NTAPS ring addresses
//               (newest sample first), an optional result-address cycle, and
//               a one-cycle done pulse. All state updates on the falling edge.
//               Build option CTRL_REGFPTR_TRISTATE_EN: when defined, ares/aerr
//               float (Z) while neither valid is set; otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_regfptr #(
  parameter int NCH   = 2,
  parameter int CW    = 1,
  parameter int DW    = 3,
  parameter int DEPTH = 8,
  parameter int NTAPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_init,
  input  logic             new_smp,
  input  logic             en_load,
  input  logic             out_smp,
  input  logic [CW-1:0]    ch_sel,
  input  logic [CW+DW-1:0] result_reg,
  input  logic [CW+DW-1:0] error_reg,
  output logic [CW+DW-1:0] ares,
  output logic [CW+DW-1:0] aerr,
  output logic             addr_vld,
  output logic             res_vld,
  output logic             busy,
  output logic             done
);

  // Fill count must represent 0..DEPTH inclusive.
  localparam int c_CNTW = $clog2(DEPTH + 1);
  localparam int c_AW   = CW + DW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RES  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ring pointer step helpers; DEPTH need not be a power of two.
  function automatic logic [DW-1:0] ptr_inc(input logic [DW-1:0] p);
    return (p == DW'(DEPTH - 1)) ? '0 : p + DW'(1);
  endfunction

  function automatic logic [DW-1:0] ptr_dec(input logic [DW-1:0] p);
    return (p == '0) ? DW'(DEPTH - 1) : p - DW'(1);
  endfunction

  // Per-channel ring state.
  logic [DW-1:0]     wp_q  [NCH];
  logic [DW-1:0]     wp_d  [NCH];
  logic [c_CNTW-1:0] cnt_q [NCH];
  logic [c_CNTW-1:0] cnt_d [NCH];

  // Walk state and snapshot.
  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [DW-1:0]     ptr_q, ptr_d;
  logic [c_CNTW-1:0] rem_q, rem_d;
  logic              osmp_q, osmp_d;
  logic [c_AW-1:0]   res_q, res_d;
  logic [c_AW-1:0]   err_q, err_d;

  logic [DW-1:0]     sel_wp;
  logic [c_CNTW-1:0] sel_cnt;
  logic [c_CNTW-1:0] load_n;
  logic              abort;
  logic [c_AW-1:0]   ares_val;

  // Channel pointer/count next state; en_init wins over new_smp.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wp_d[c]  = wp_q[c];
      cnt_d[c] = cnt_q[c];
      if (ch_sel == CW'(c)) begin
        if (en_init) begin
          wp_d[c]  = '0;
          cnt_d[c] = '0;
        end else if (new_smp) begin
          wp_d[c]  = ptr_inc(wp_q[c]);
          cnt_d[c] = (cnt_q[c] == c_CNTW'(DEPTH)) ? cnt_q[c] : cnt_q[c] + c_CNTW'(1);
        end
      end
    end
  end

  // The snapshot sees the selected channel after this cycle's update.
  assign sel_wp  = wp_d[ch_sel];
  assign sel_cnt = cnt_d[ch_sel];
  assign load_n  = (sel_cnt > c_CNTW'(NTAPS)) ? c_CNTW'(NTAPS) : sel_cnt;
  assign abort   = en_init && (ch_sel == ch_q);

  // Channel ring registers.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wp_q[c]  <= wp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Walk FSM next-state and snapshot capture.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    osmp_d  = osmp_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (en_load) begin
          ch_d   = ch_sel;
          ptr_d  = ptr_dec(sel_wp);
          rem_d  = load_n;
          osmp_d = out_smp;
          res_d  = result_reg;
          err_d  = error_reg;
          if (load_n != '0)  state_d = ST_WALK;
          else if (out_smp)  state_d = ST_RES;
          else               state_d = ST_DONE;
        end
      end
      ST_WALK: begin
        ptr_d = ptr_dec(ptr_q);
        rem_d = rem_q - c_CNTW'(1);
        if (rem_q == c_CNTW'(1)) state_d = osmp_q ? ST_RES : ST_DONE;
      end
      ST_RES:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    // Clearing the channel being walked kills the walk with no done pulse.
    if ((state_q != ST_IDLE) && abort) state_d = ST_IDLE;
  end

  // Walk FSM and snapshot registers.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      osmp_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      osmp_q  <= osmp_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Status flags decode straight from the state register, so reset clears them at once.
  assign addr_vld = (state_q == ST_WALK);
  assign res_vld  = (state_q == ST_RES);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign ares_val = addr_vld ? {ch_q, ptr_q} : res_q;

`ifdef CTRL_REGFPTR_TRISTATE_EN
  assign ares = (addr_vld || res_vld) ? ares_val : {c_AW{1'bz}};
  assign aerr = (addr_vld || res_vld) ? err_q    : {c_AW{1'bz}};
`else
  assign ares = (addr_vld || res_vld) ? ares_val : '0;
  assign aerr = (addr_vld || res_vld) ? err_q    : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_regfptr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_regfptr
// Description : Directed self-checking bench for ctrl_regfptr (default
//               parameters). Honours CTRL_REGFPTR_TRISTATE_EN for the
//               expected idle value of ares/aerr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_regfptr;

`ifdef CTRL_REGFPTR_TRISTATE_EN
  localparam logic [3:0] IA = 4'bzzzz;
`else
  localparam logic [3:0] IA = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_init, new_smp, en_load, out_smp;
  logic [0:0] ch_sel;
  logic [3:0] result_reg, error_reg;
  logic [3:0] ares, aerr;
  logic       addr_vld, res_vld, busy, done;

  int n_pass = 0;
  int n_chk  = 0;

  ctrl_regfptr dut (
    .clk        (clk),
    .rst        (rst),
    .en_init    (en_init),
    .new_smp    (new_smp),
    .en_load    (en_load),
    .out_smp    (out_smp),
    .ch_sel     (ch_sel),
    .result_reg (result_reg),
    .error_reg  (error_reg),
    .ares       (ares),
    .aerr       (aerr),
    .addr_vld   (addr_vld),
    .res_vld    (res_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Active edge is the falling edge; look at outputs 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // flags = {addr_vld, res_vld, busy, done}
  task automatic chk(input string tag, input logic [3:0] ea, input logic [3:0] ee,
                     input logic [3:0] ef);
    logic [11:0] obs, expv;
    obs  = {ares, aerr, addr_vld, res_vld, busy, done};
    expv = {ea, ee, ef};
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed ares=%b aerr=%b flags=%b expected ares=%b aerr=%b flags=%b",
                tag, obs[11:8], obs[7:4], obs[3:0], ea, ee, ef);
  endtask

  initial begin
    rst = 1'b0; en_init = 0; new_smp = 0; en_load = 0; out_smp = 0;
    ch_sel = 0; result_reg = 0; error_reg = 0;
    #1;
    chk("reset", IA, IA, 4'b0000);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_reset_idle", IA, IA, 4'b0000);

    // Three samples on ch0, then a walk without result cycle.
    ch_sel = 0; new_smp = 1;
    tick(); tick(); tick();
    new_smp = 0; en_load = 1; out_smp = 0; error_reg = 4'h9;
    tick(); en_load = 0;
    chk("s1_walk0", 4'h2, 4'h9, 4'b1010);
    tick(); chk("s1_walk1", 4'h1, 4'h9, 4'b1010);
    tick(); chk("s1_walk2", 4'h0, 4'h9, 4'b1010);
    tick(); chk("s1_done",  IA,   IA,   4'b0011);
    tick(); chk("s1_idle",  IA,   IA,   4'b0000);

    // Ten samples on ch1: wp wraps to 2, count saturates at 8.
    ch_sel = 1; new_smp = 1;
    for (int i = 0; i < 10; i++) tick();
    new_smp = 0; en_load = 1; out_smp = 1; result_reg = 4'h5; error_reg = 4'hA;
    tick(); en_load = 0; out_smp = 0;
    chk("s2_walk0", 4'h9, 4'hA, 4'b1010);
    tick(); chk("s2_walk1", 4'h8, 4'hA, 4'b1010);
    tick(); chk("s2_walk2", 4'hF, 4'hA, 4'b1010);
    tick(); chk("s2_walk3", 4'hE, 4'hA, 4'b1010);
    tick(); chk("s2_res",   4'h5, 4'hA, 4'b0110);
    tick(); chk("s2_done",  IA,   IA,   4'b0011);
    tick(); chk("s2_idle",  IA,   IA,   4'b0000);

    // Empty channel: straight to the result cycle.
    ch_sel = 0; en_init = 1;
    tick(); en_init = 0;
    en_load = 1; out_smp = 1; result_reg = 4'h3; error_reg = 4'h6;
    tick(); en_load = 0; out_smp = 0;
    chk("s3_res",  4'h3, 4'h6, 4'b0110);
    tick(); chk("s3_done", IA, IA, 4'b0011);
    tick(); chk("s3_idle", IA, IA, 4'b0000);

    // New sample mid-walk leaves the snapshot alone.
    ch_sel = 0; new_smp = 1;
    tick(); tick(); tick();
    new_smp = 0; en_load = 1; out_smp = 0; error_reg = 4'h1;
    tick(); en_load = 0;
    chk("s4_walk0", 4'h2, 4'h1, 4'b1010);
    new_smp = 1;
    tick(); new_smp = 0;
    chk("s4_walk1", 4'h1, 4'h1, 4'b1010);
    tick(); chk("s4_walk2", 4'h0, 4'h1, 4'b1010);
    tick(); chk("s4_done",  IA,   IA,   4'b0011);
    tick();
    en_load = 1; error_reg = 4'h2;
    tick(); en_load = 0;
    chk("s4b_walk0", 4'h3, 4'h2, 4'b1010);
    tick(); chk("s4b_walk1", 4'h2, 4'h2, 4'b1010);
    tick(); chk("s4b_walk2", 4'h1, 4'h2, 4'b1010);
    tick(); chk("s4b_walk3", 4'h0, 4'h2, 4'b1010);
    tick(); chk("s4b_done",  IA,   IA,   4'b0011);
    tick();

    // Abort: load on other channel while busy is ignored, then en_init kills the walk.
    ch_sel = 1; en_load = 1; out_smp = 1; result_reg = 4'h5; error_reg = 4'h2;
    tick(); out_smp = 0;
    chk("s5_walk0", 4'h9, 4'h2, 4'b1010);
    ch_sel = 0;
    tick(); en_load = 0;
    chk("s5_walk1_ign", 4'h8, 4'h2, 4'b1010);
    ch_sel = 1; en_init = 1;
    tick(); en_init = 0;
    chk("s5_abort_idle", IA, IA, 4'b0000);
    tick(); chk("s5_no_done", IA, IA, 4'b0000);

    // Asynchronous reset mid-walk.
    ch_sel = 1; new_smp = 1;
    tick(); tick();
    new_smp = 0; en_load = 1; out_smp = 1; result_reg = 4'h5; error_reg = 4'h7;
    tick(); en_load = 0; out_smp = 0;
    chk("s6_walk0", 4'h9, 4'h7, 4'b1010);
    #2 rst = 1'b0;
    #1 chk("s6_async_rst", IA, IA, 4'b0000);
    tick(); chk("s6_held", IA, IA, 4'b0000);
    rst = 1'b1;
    tick(); chk("s6_release", IA, IA, 4'b0000);
    // ch0 was cleared: load with same-cycle sample gives exactly one tap at 0.
    ch_sel = 0; new_smp = 1; en_load = 1; error_reg = 4'h4;
    tick(); new_smp = 0; en_load = 0;
    chk("s6_ch0_walk0", 4'h0, 4'h4, 4'b1010);
    tick(); chk("s6_ch0_done", IA, IA, 4'b0011);
    tick();
    // ch1 was cleared: no taps, no result cycle, straight to done.
    ch_sel = 1; en_load = 1;
    tick(); en_load = 0;
    chk("s6_ch1_done", IA, IA, 4'b0011);
    tick(); chk("s6_ch1_idle", IA, IA, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_regfptr.md
CTRL_REGFPTR -- requirements
Module: ctrl_regfptr

Interface
REQ-001 Parameter NCH, default 2: number of sample channels, at least 1.
REQ-002 Parameter CW, default 1: channel index width, equal to max(1, clog2(NCH)).
REQ-003 Parameter DW, default 3: ring pointer width.
REQ-004 Parameter DEPTH, default 8: ring length per channel, 2 to 2^DW.
REQ-005 Parameter NTAPS, default 4: maximum addresses per walk, 1 to DEPTH.
REQ-006 clk  in  1: clock; all registers update on the falling edge.
REQ-007 rst  in  1: asynchronous, active-low reset.
REQ-008 en_init  in  1: clear the ring state of channel ch_sel.
REQ-009 new_smp  in  1: new sample written to channel ch_sel; advance its write pointer.
REQ-010 en_load  in  1: start an address walk on channel ch_sel.
REQ-011 out_smp  in  1: output sample due; append a result-address cycle to the walk.
REQ-012 ch_sel  in  CW: channel select for en_init, new_smp and en_load.
REQ-013 result_reg  in  CW+DW: result register address.
REQ-014 error_reg  in  CW+DW: error register address.
REQ-015 ares  out  CW+DW: result/sample register-file address.
REQ-016 aerr  out  CW+DW: error register-file address.
REQ-017 addr_vld  out  1: ares carries a ring (tap) address.
REQ-018 res_vld  out  1: ares carries the result address.
REQ-019 busy  out  1: a walk is in progress.
REQ-020 done  out  1: one-cycle pulse at the end of a walk.

Function
REQ-021 Per channel, the block SHALL hold a write pointer wp[ch] (DW bits) and a fill count cnt[ch] (0..DEPTH).
REQ-022 new_smp SHALL set wp to wp+1, wrapping DEPTH-1 to 0, and SHALL increment cnt, saturating at DEPTH.
REQ-023 en_init SHALL set wp and cnt of ch_sel to 0; en_init has priority over new_smp on the same cycle.
REQ-024 The FSM SHALL have four states: IDLE, WALK, RES and DONE; busy is 1 in every state except IDLE.
REQ-025 In IDLE, en_load SHALL snapshot the following values:
  - ch_sel;
  - base = wp, after any same-cycle new_smp on the same channel;
  - n = min(NTAPS, cnt), using the same post-update count;
  - out_smp, result_reg and error_reg.
REQ-026 From IDLE on en_load, the FSM SHALL go to WALK if n>0, else to RES if out_smp was latched, else to DONE.
REQ-027 WALK SHALL emit one address per cycle: ares = {ch, base-1-k} for k = 0..n-1, with DEPTH-modulo wrap, and addr_vld=1.
REQ-028 The first address SHALL appear the cycle after en_load is sampled.
REQ-029 After the last WALK address, the FSM SHALL go to RES if out_smp was latched, else to DONE.
REQ-030 RES SHALL last one cycle with ares = latched result_reg and res_vld=1.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 aerr SHALL equal the latched error_reg whenever addr_vld or res_vld is 1.
REQ-033 en_load while busy SHALL be ignored.
REQ-034 new_smp and en_init while busy SHALL update channel state but SHALL NOT alter the walk snapshot.
REQ-035 en_init on the walking channel while busy SHALL abort the walk: the FSM returns to IDLE next cycle without a done pulse.
REQ-036 When neither valid is 1, ares and aerr SHALL be driven per REQ-040.

Reset
REQ-037 rst=0 SHALL immediately force the FSM to IDLE, every wp and cnt to 0, and all snapshot registers to 0.
REQ-038 rst=0 SHALL immediately force addr_vld, res_vld, busy and done to 0.
REQ-039 Reset asserted mid-walk SHALL terminate the walk with no done pulse; operation resumes on the first falling edge after rst=1.

Configuration
REQ-040 Macro CTRL_REGFPTR_TRISTATE_EN SHALL select the idle drive of ares and aerr:
  - defined: ares and aerr are high-impedance whenever addr_vld=0 and res_vld=0, for a shared bus;
  - undefined: ares and aerr are driven to 0 in that case.

Verification
REQ-041 Bench SHALL cover: reset, then 3x new_smp on ch0, then en_load with out_smp=0 -> ares 2,1,0 with addr_vld, then done pulse, busy for 4 cycles.
REQ-042 Bench SHALL cover wrap: DEPTH=8, 10x new_smp on ch1, then en_load with out_smp=1 and result_reg=5 -> ares {1,1},{1,0},{1,7},{1,6}, then ares=5 with res_vld, then done.
REQ-043 Bench SHALL cover an empty channel: en_init on ch0, then en_load with out_smp=1 -> RES immediately (one cycle, ares=result_reg), then done; no addr_vld.
REQ-044 Bench SHALL cover a mid-walk event: new_smp on the same channel during WALK -> remaining addresses unchanged; a following walk starts at the new wp-1.
REQ-045 Bench SHALL cover abort: en_init on the walking channel at the second WALK cycle -> IDLE next cycle, no done; en_load while busy on the other channel is ignored.
REQ-046 Bench SHALL cover async reset mid-walk: rst=0 between edges -> all outputs 0 (or Z per REQ-040) at once, no done; build with and without CTRL_REGFPTR_TRISTATE_EN.
